cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
Slave end of the CPU memory/I/O bus: samples the CPU's address, write data, strobes and byte mode, and services each transaction from an internal word-wide RAM or a small I/O register file. Each transaction ends with one `mem_rdy` pulse and, for reads, returned `rd_data`. Used as the bus-facing memory model for simulation and as the on-chip RAM/IO responder in FPGA builds.

Parameters:
AW, 14, RAM word-address width; RAM size is 2^AW 16-bit words.
WAIT_STATES, 0, extra cycles inserted before every access, including both halves of a split access.
IO_REGS_LOG2, 4, log2 of the number of 16-bit I/O registers.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
addr  in  20  byte address from the CPU
wr_data  in  16  write data; low byte used for byte writes
we  in  1  1 = write, 0 = read
m_io  in  1  1 = I/O space, 0 = memory space
byte_m  in  1  1 = byte access, 0 = word access
mem_op  in  1  transaction request level
wr_cnd  in  1  write-commit qualifier; used only with the optional feature
rd_data  out  16  read data, registered
mem_rdy  out  1  single-cycle completion pulse, registered

Behaviour:
- Reset: `rst` high asynchronously forces state IDLE, `mem_rdy`=0, `rd_data`=0, all I/O registers=0. RAM contents are not reset.
- FSM states are IDLE, WAIT1, ACC1, WAIT2, ACC2, DONE.
- IDLE: when `mem_op`=1 at a clock edge:
  - latch `addr`, `wr_data`, `we`, `m_io` and `byte_m`;
  - load the wait counter with WAIT_STATES;
  - go to WAIT1, or directly to ACC1 when WAIT_STATES=0.
- While not in IDLE, changes on the inputs are ignored.
- WAIT1/WAIT2: decrement the counter; on 0, go to ACC1/ACC2.
- A split access is a memory word access with latched `addr[0]`=1.
- ACC1:
  - For a write, write the first lane at this edge; for a read, capture it into `rd_data`.
  - A split access then goes to WAIT2/ACC2; any other access goes to DONE.
- ACC2: handles the second half of a split access, then goes to DONE.
- DONE: `mem_rdy`=1 for this one cycle only; the FSM returns to IDLE unconditionally.
- Bus rule: if `mem_op` is still high in the IDLE cycle after DONE, that starts a new transaction.
- Latency, counted from the edge that samples `mem_op` in IDLE:
  - `mem_rdy` rises 2+WAIT_STATES edges later for non-split accesses;
  - `mem_rdy` rises 3+2*WAIT_STATES edges later for split accesses.
- Memory word index is `addr[AW:1]`; higher address bits alias.
- Aligned word access reads or writes the whole word.
- Byte access:
  - `addr[0]`=0 selects bits [7:0] and `addr[0]`=1 selects bits [15:8];
  - a byte read returns {8'h00, byte};
  - a byte write stores `wr_data[7:0]` into the selected lane.
- Split word access:
  - ACC1 handles the high byte of word W, which maps to the data low byte;
  - ACC2 handles the low byte of word W+1 (mod 2^AW), which maps to the data high byte;
  - so the top word wraps to word 0.
- I/O space:
  - register index is `addr[IO_REGS_LOG2:1]`;
  - addresses with `addr[19:IO_REGS_LOG2+1]` nonzero read 16'hFFFF, and writes to them are dropped;
  - I/O accesses are never split, because `addr[0]` is ignored for word I/O; byte I/O uses the lane rule above.
- `rd_data` holds its value until the next read captures new data; writes leave it unchanged.
- Reset mid-transaction: the FSM aborts with no `mem_rdy`. A split write whose ACC1 already executed keeps its first byte; there is no rollback.

Optional Feature:
- Macro: BUS_WR_CND_EN.
- Defined: a write lane commits only if `wr_cnd`=1 at that ACC edge. Otherwise the write is suppressed, but the timing and `mem_rdy` pulse are unchanged.
- Undefined: `wr_cnd` is ignored and all writes commit.

Decomposition:
- Shared defines file holds:
  - the FSM state encodings (3 bits);
  - the I/O open-bus value 16'hFFFF;
  - the lane-select macros.
- One sub-module, `bus_resp_ram`:
  - single-port 2^AW x 16 array;
  - two byte-write enables;
  - asynchronous read.
- The FSM, wait counter, lane steering and I/O register file stay in the top module.

Test Plan:
- Aligned write and read, WAIT_STATES=0: word write 0x00010 <- 0xBEEF, then word read 0x00010 -> `rd_data`=0xBEEF; `mem_rdy` pulses 2 edges after the sampling edge, one cycle wide.
- Byte lanes: after test 1, byte write 0x00011 <- 0x12, then word read 0x00010 -> 0x12EF; byte read 0x00010 -> 0x00EF; byte read 0x00011 -> 0x0012.
- Split write: with words 0x00020 and 0x00022 preset to 0x0000, word write 0x00021 <- 0xA55A -> word read 0x00020 = 0x5A00 and 0x00022 = 0x00A5; split word read 0x00021 -> 0xA55A with `mem_rdy` at edge 3; the same access at the top byte address wraps its high byte into word 0.
- I/O space: `m_io`=1 write 0x00006 <- 0x1234, read 0x00006 -> 0x1234; read 0x00040 -> 0xFFFF; write 0x00040 changes no register.
- Wait states: WAIT_STATES=3 gives aligned read `mem_rdy` at edge 5 and split read at edge 9; toggling `addr` during WAIT1 does not alter the result.
- Reset and `wr_cnd`:
  - `rst` pulsed during WAIT1 of a write -> no `mem_rdy`, target word unchanged, outputs 0;
  - with BUS_WR_CND_EN, a write with `wr_cnd`=0 -> `mem_rdy` pulses but the memory is unchanged.

Source files
------------

// File: rtl/cpu_bus_responder_pkg.sv
// Shared types and constants for the CPU bus responder: FSM state encoding,
// I/O open-bus value and byte-lane helpers.
package cpu_bus_responder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    ACC1  = 3'd2,
    WAIT2 = 3'd3,
    ACC2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] IO_OPEN_BUS = 16'hFFFF;
  localparam logic        LANE_LO     = 1'b0;
  localparam logic        LANE_HI     = 1'b1;

  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/cpu_bus_responder_bus_resp_ram.sv
// Single-port 2^AW x 16 RAM with per-byte write enables and asynchronous read.
module bus_resp_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic          we_lo,
  input  logic          we_hi,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_lo) mem[addr][7:0]  <= wdata[7:0];
    if (we_hi) mem[addr][15:8] <= wdata[15:8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus slave: services memory/I/O transactions from an internal RAM or an
// I/O register file. Optional write-commit qualifier enabled by BUS_WR_CND_EN.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int AW           = 14,
  parameter int WAIT_STATES  = 0,
  parameter int IO_REGS_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] addr,
  input  logic [15:0] wr_data,
  input  logic        we,
  input  logic        m_io,
  input  logic        byte_m,
  input  logic        mem_op,
  input  logic        wr_cnd,
  output logic [15:0] rd_data,
  output logic        mem_rdy
);

  localparam int CW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int N_IO   = 2 ** IO_REGS_LOG2;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [19:0]     addr_reg;
  logic [15:0]     wdata_reg;
  logic            we_reg, mio_reg, byte_reg;
  logic [15:0]     rd_data_reg, rd_data_next;
  logic            mem_rdy_reg, mem_rdy_next;
  logic [15:0]     io_regs [N_IO];

  logic [AW-1:0]           word_idx, ram_addr;
  logic [15:0]             ram_wdata, ram_rdata;
  logic                    ram_we_lo, ram_we_hi;
  logic [IO_REGS_LOG2-1:0] io_idx;
  logic                    io_hit;
  logic [15:0]             io_rdata, io_wdata;
  logic [N_IO-1:0]         io_we_lo, io_we_hi;
  logic                    split, commit;

`ifdef BUS_WR_CND_EN
  assign commit = wr_cnd;
`else
  assign commit = 1'b1;
  logic unused_wr_cnd;
  assign unused_wr_cnd = wr_cnd;
`endif

  assign word_idx = addr_reg[AW:1];
  assign ram_addr = (state_reg == ACC2) ? word_idx + AW'(1) : word_idx;
  assign split    = !mio_reg && !byte_reg && addr_reg[0];
  assign io_idx   = addr_reg[IO_REGS_LOG2:1];
  assign io_hit   = (addr_reg[19:IO_REGS_LOG2+1] == '0);
  assign io_rdata = io_hit ? io_regs[io_idx] : IO_OPEN_BUS;

  bus_resp_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .we_lo (ram_we_lo),
    .we_hi (ram_we_hi),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rd_data_reg <= '0;
      mem_rdy_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_data_reg <= rd_data_next;
      mem_rdy_reg <= mem_rdy_next;
    end
  end

  // Request fields are frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      mio_reg   <= 1'b0;
      byte_reg  <= 1'b0;
    end else if (state_reg == IDLE && mem_op) begin
      addr_reg  <= addr;
      wdata_reg <= wr_data;
      we_reg    <= we;
      mio_reg   <= m_io;
      byte_reg  <= byte_m;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rd_data_next = rd_data_reg;
    mem_rdy_next = 1'b0;
    ram_we_lo    = 1'b0;
    ram_we_hi    = 1'b0;
    ram_wdata    = wdata_reg;
    io_we_lo     = '0;
    io_we_hi     = '0;
    io_wdata     = wdata_reg;

    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          cnt_next   = CW'(WAIT_STATES);
          state_next = (WAIT_STATES == 0) ? ACC1 : WAIT1;
        end
      end

      WAIT1: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_next == '0) state_next = ACC1;
      end

      ACC1: begin
        if (mio_reg) begin
          if (we_reg) begin
            if (commit && io_hit) begin
              if (byte_reg) begin
                io_wdata = {2{wdata_reg[7:0]}};
                if (addr_reg[0]) io_we_hi[io_idx] = 1'b1;
                else             io_we_lo[io_idx] = 1'b1;
              end else begin
                io_we_lo[io_idx] = 1'b1;
                io_we_hi[io_idx] = 1'b1;
              end
            end
          end else if (byte_reg) begin
            rd_data_next = {8'h00, lane_sel(io_rdata, addr_reg[0])};
          end else begin
            rd_data_next = io_rdata;
          end
        end else if (byte_reg || split) begin
          // Split ACC1 touches the high lane of word W with the data low byte.
          if (we_reg) begin
            ram_wdata = {2{wdata_reg[7:0]}};
            ram_we_hi = commit && addr_reg[0];
            ram_we_lo = commit && !addr_reg[0];
          end else if (split) begin
            rd_data_next = {rd_data_reg[15:8], ram_rdata[15:8]};
          end else begin
            rd_data_next = {8'h00, lane_sel(ram_rdata, addr_reg[0])};
          end
        end else begin
          if (we_reg) begin
            ram_we_lo = commit;
            ram_we_hi = commit;
          end else begin
            rd_data_next = ram_rdata;
          end
        end

        if (split) begin
          cnt_next   = CW'(WAIT_STATES);
          state_next = (WAIT_STATES == 0) ? ACC2 : WAIT2;
        end else begin
          state_next = DONE;
        end
      end

      WAIT2: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_next == '0) state_next = ACC2;
      end

      ACC2: begin
        if (we_reg) begin
          ram_wdata = {2{wdata_reg[15:8]}};
          ram_we_lo = commit;
        end else begin
          rd_data_next = {ram_rdata[7:0], rd_data_reg[7:0]};
        end
        state_next = DONE;
      end

      DONE: begin
        mem_rdy_next = 1'b1;
        state_next   = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IO; gi++) begin : g_io
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          io_regs[gi] <= '0;
        end else begin
          if (io_we_lo[gi]) io_regs[gi][7:0]  <= io_wdata[7:0];
          if (io_we_hi[gi]) io_regs[gi][15:8] <= io_wdata[15:8];
        end
      end
    end
  endgenerate

  assign rd_data = rd_data_reg;
  assign mem_rdy = mem_rdy_reg;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: one instance with no wait states and
// one with three, each driven through its own request signals.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [19:0] addr0 = '0, addr3 = '0;
  logic [15:0] wd0 = '0, wd3 = '0;
  logic        we0 = 0, we3 = 0, mio0 = 0, mio3 = 0, bm0 = 0, bm3 = 0;
  logic        op0 = 0, op3 = 0, wc0 = 1, wc3 = 1;
  logic [15:0] rd0, rd3;
  logic        rdy0, rdy3;
  logic        wc_val = 1'b1;

  int errors = 0;
  int checks = 0;

  cpu_bus_responder #(.AW(14), .WAIT_STATES(0), .IO_REGS_LOG2(4)) dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .wr_data(wd0), .we(we0), .m_io(mio0),
    .byte_m(bm0), .mem_op(op0), .wr_cnd(wc0), .rd_data(rd0), .mem_rdy(rdy0)
  );

  cpu_bus_responder #(.AW(14), .WAIT_STATES(3), .IO_REGS_LOG2(4)) dut3 (
    .clk(clk), .rst(rst), .addr(addr3), .wr_data(wd3), .we(we3), .m_io(mio3),
    .byte_m(bm3), .mem_op(op3), .wr_cnd(wc3), .rd_data(rd3), .mem_rdy(rdy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One bus transaction; returns mem_rdy latency in edges (-1 on timeout).
  task automatic xfer(input int sel, input logic [19:0] a, input logic [15:0] d,
                      input logic w, input logic io, input logic bm, input logic tog,
                      output int lat, output logic [15:0] rdv);
    logic r;
    @(negedge clk);
    if (sel == 0) begin
      addr0 = a; wd0 = d; we0 = w; mio0 = io; bm0 = bm; wc0 = wc_val; op0 = 1'b1;
    end else begin
      addr3 = a; wd3 = d; we3 = w; mio3 = io; bm3 = bm; wc3 = wc_val; op3 = 1'b1;
    end
    @(posedge clk);
    #1;
    op0 = 1'b0; op3 = 1'b0;
    if (tog) begin
      if (sel == 0) begin addr0 = ~a; wd0 = ~d; we0 = ~w; end
      else          begin addr3 = ~a; wd3 = ~d; we3 = ~w; end
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      r = (sel == 0) ? rdy0 : rdy3;
      if (r) begin
        lat = n;
        break;
      end
    end
    rdv = (sel == 0) ? rd0 : rd3;
    @(posedge clk);
    #1;
    r = (sel == 0) ? rdy0 : rdy3;
    check("rdy_one_cycle", {31'd0, r}, 32'd0);
  endtask

  task automatic do_wr(input string tag, input int sel, input logic [19:0] a,
                       input logic [15:0] d, input logic io, input logic bm, input int exp_lat);
    int lat;
    logic [15:0] rdv;
    xfer(sel, a, d, 1'b1, io, bm, 1'b0, lat, rdv);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic do_rd(input string tag, input int sel, input logic [19:0] a,
                       input logic io, input logic bm, input logic tog,
                       input int exp_lat, input logic [15:0] exp_data);
    int lat;
    logic [15:0] rdv;
    xfer(sel, a, 16'h0000, 1'b0, io, bm, tog, lat, rdv);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {16'd0, rdv}, {16'd0, exp_data});
  endtask

  initial begin
    int seen;
    #12;
    check("reset_rd0", {16'd0, rd0}, 32'd0);
    check("reset_rdy0", {31'd0, rdy0}, 32'd0);
    check("reset_rd3", {16'd0, rd3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned word and byte lanes
    do_wr("wr_10", 0, 20'h00010, 16'hBEEF, 1'b0, 1'b0, 2);
    do_rd("rd_10", 0, 20'h00010, 1'b0, 1'b0, 1'b0, 2, 16'hBEEF);
    do_wr("bwr_11", 0, 20'h00011, 16'h0012, 1'b0, 1'b1, 2);
    do_rd("rd_10b", 0, 20'h00010, 1'b0, 1'b0, 1'b0, 2, 16'h12EF);
    do_rd("brd_10", 0, 20'h00010, 1'b0, 1'b1, 1'b0, 2, 16'h00EF);
    do_rd("brd_11", 0, 20'h00011, 1'b0, 1'b1, 1'b0, 2, 16'h0012);

    // Split access and top-word wrap
    do_wr("pre_20", 0, 20'h00020, 16'h0000, 1'b0, 1'b0, 2);
    do_wr("pre_22", 0, 20'h00022, 16'h0000, 1'b0, 1'b0, 2);
    do_wr("swr_21", 0, 20'h00021, 16'hA55A, 1'b0, 1'b0, 3);
    do_rd("rd_20", 0, 20'h00020, 1'b0, 1'b0, 1'b0, 2, 16'h5A00);
    do_rd("rd_22", 0, 20'h00022, 1'b0, 1'b0, 1'b0, 2, 16'h00A5);
    do_rd("srd_21", 0, 20'h00021, 1'b0, 1'b0, 1'b0, 3, 16'hA55A);
    do_wr("pre_0", 0, 20'h00000, 16'h1111, 1'b0, 1'b0, 2);
    do_wr("pre_top", 0, 20'h07FFE, 16'h2222, 1'b0, 1'b0, 2);
    do_wr("swr_top", 0, 20'h07FFF, 16'hC33C, 1'b0, 1'b0, 3);
    do_rd("rd_0", 0, 20'h00000, 1'b0, 1'b0, 1'b0, 2, 16'h11C3);
    do_rd("rd_top", 0, 20'h07FFE, 1'b0, 1'b0, 1'b0, 2, 16'h3C22);
    do_rd("srd_top", 0, 20'h07FFF, 1'b0, 1'b0, 1'b0, 3, 16'hC33C);
    do_rd("alias_10", 0, 20'h08010, 1'b0, 1'b0, 1'b0, 2, 16'h12EF);

    // I/O space
    do_wr("io_wr_6", 0, 20'h00006, 16'h1234, 1'b1, 1'b0, 2);
    do_rd("io_rd_6", 0, 20'h00006, 1'b1, 1'b0, 1'b0, 2, 16'h1234);
    do_rd("io_brd_7", 0, 20'h00007, 1'b1, 1'b1, 1'b0, 2, 16'h0012);
    do_rd("io_rd_40", 0, 20'h00040, 1'b1, 1'b0, 1'b0, 2, 16'hFFFF);
    do_wr("io_wr_40", 0, 20'h00040, 16'hDEAD, 1'b1, 1'b0, 2);
    do_rd("io_rd_0", 0, 20'h00000, 1'b1, 1'b0, 1'b0, 2, 16'h0000);
    do_rd("io_rd_6b", 0, 20'h00006, 1'b1, 1'b0, 1'b0, 2, 16'h1234);

    // Wait states, inputs toggled while busy
    do_wr("w3_wr_10", 1, 20'h00010, 16'h7777, 1'b0, 1'b0, 5);
    do_rd("w3_rd_10", 1, 20'h00010, 1'b0, 1'b0, 1'b1, 5, 16'h7777);
    do_wr("w3_swr_21", 1, 20'h00021, 16'h1234, 1'b0, 1'b0, 9);
    do_rd("w3_srd_21", 1, 20'h00021, 1'b0, 1'b0, 1'b1, 9, 16'h1234);

    // Reset during WAIT1 of a write
    do_wr("w3_pre_30", 1, 20'h00030, 16'h4444, 1'b0, 1'b0, 5);
    @(negedge clk);
    addr3 = 20'h00030; wd3 = 16'h9999; we3 = 1'b1; mio3 = 1'b0; bm3 = 1'b0; op3 = 1'b1;
    @(posedge clk);
    #1;
    op3 = 1'b0;
    rst = 1'b1;
    #3;
    check("rst_rd3", {16'd0, rd3}, 32'd0);
    check("rst_rdy3", {31'd0, rdy3}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (rdy3) seen++;
    end
    check("rst_no_rdy", seen, 0);
    do_rd("rst_rd_30", 1, 20'h00030, 1'b0, 1'b0, 1'b0, 5, 16'h4444);
    do_rd("rst_io_6", 0, 20'h00006, 1'b1, 1'b0, 1'b0, 2, 16'h0000);

`ifdef BUS_WR_CND_EN
    wc_val = 1'b0;
    do_wr("cnd_wr_10", 0, 20'h00010, 16'h5555, 1'b0, 1'b0, 2);
    wc_val = 1'b1;
    do_rd("cnd_rd_10", 0, 20'h00010, 1'b0, 1'b0, 1'b0, 2, 16'h12EF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
